counter_mode_ctrl: RTL and testbench
====================================

Name: counter_mode_ctrl

Overview:
- Consumer end of the one-hot `key_select` interface produced by the key-control block. Decodes the selection into a counter command: up, down, pause or clear.
- Runs a prescaled, multi-digit BCD up/down counter for the display path of the counter design.
- Sits between key control and the segment/LED driver.

Parameters:
- CNT_MAX, 26'd49_999_999, prescaler terminal value; one count step every CNT_MAX+1 clocks (1 s at 50 MHz).
- DIGITS, 4, number of BCD decades in the counter.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  asynchronous, active-high reset.
- key_select  input  4  one-hot selection: 0001 up, 0010 down, 0100 pause, 1000 clear, 0000 none.
- cnt_bcd  output  4*DIGITS  BCD count, digit 0 in bits [3:0].
- mode  output  2  current mode: 00 HOLD, 01 UP, 10 DOWN.
- step  output  1  one-cycle pulse on each count step.
- wrap  output  1  one-cycle pulse when the counter wraps.
- sel_err  output  1  one-cycle pulse when `key_select` changes to a non-one-hot, non-zero value.

Behaviour:
- Reset (asynchronous, active-high): `cnt_bcd`=0, `mode`=HOLD, prescaler=0, previous-select register=0000. `step`, `wrap` and `sel_err` are 0.
- Edge rule: `key_select` is registered as `sel_q`. A command is taken only when `key_select` != `sel_q`, i.e. a change. A steady input never re-triggers.
- Command latency: a change at clock edge n updates `mode` and the counter at edge n+1.
- Commands:
  - 0001 → UP.
  - 0010 → DOWN.
  - 0100 → HOLD.
  - 1000 → `cnt_bcd`=0, prescaler=0, `mode`=HOLD, all in the same cycle.
  - 0000 → no change.
  - Any other value: `mode` and count are held, and `sel_err` pulses one cycle.
- A mode change between UP and DOWN clears the prescaler. A change into HOLD freezes the prescaler at its current value.
- Prescaler runs only in UP or DOWN. When it equals CNT_MAX it resets to 0 and `step` pulses. On that same edge the counter moves by ±1.
- UP: decades increment with carry. All-9s goes to all-0s and `wrap` pulses in the same cycle as `step`.
- DOWN: decades decrement with borrow. All-0s goes to all-9s and `wrap` pulses.
- Each decade is always 0..9; there is no binary intermediate.
- A command and a prescaler terminal in the same cycle: the command wins. There is no step or wrap that cycle, and the prescaler follows the command rule.
- Reset asserted mid-count returns all outputs to reset values immediately, independent of the clock.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined: UP stops at all-9s and DOWN stops at all-0s. At the limit, `step` still pulses, the count is held and `wrap` pulses to flag the limit hit. `mode` stays unchanged.
- Undefined: wrap-around as described in Behaviour.

Decomposition:
- Shared package `counter_pkg`:
  - mode encodings MODE_HOLD/MODE_UP/MODE_DOWN;
  - select codes SEL_UP=4'b0001, SEL_DOWN=4'b0010, SEL_PAUSE=4'b0100, SEL_CLEAR=4'b1000;
  - BCD_MAX=4'd9.
- Sub-module `bcd_decade`:
  - one decade with inputs en, up, clr;
  - outputs digit[3:0] and carry_out (carry when up and digit is 9; borrow when down and digit is 0);
  - instantiated DIGITS times in a generate chain.
- The top handles edge detection, the mode FSM and the prescaler.

Test Plan:
- Reset, then `key_select`=0001 with CNT_MAX=3 → `mode`=01 one cycle after the change. First `step` 4 clocks later; `cnt_bcd` 0000→0001→0002.
- Preload 9998 via repeated UP steps (CNT_MAX=0) → 9999, then 0000 with a `wrap` pulse coincident with `step`. Under COUNTER_SATURATE_EN the count holds 9999 and `wrap` still pulses.
- From 0000, `key_select`=0010 → next step gives 9999 with `wrap`. Count 1000 down → 0999 (borrow chain across decades).
- Counting at 0042, `key_select`=0100 → `mode`=00, no further steps. Then 0001 → counting resumes from the frozen prescaler value.
- Counting, `key_select`=1000 → `cnt_bcd`=0000, `mode`=00 next cycle. Holding 1000 for 100 cycles has no further effect.
- `key_select`=0011 → `sel_err` pulses once, `mode` and count unchanged. Separately, assert `sys_rst` mid-cycle → all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter display path: mode encodings, one-hot
// key-select codes and BCD limits used by counter_mode_ctrl and bcd_decade.
package counter_pkg;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned PRESC_W = 26;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10
    } mode_e;

    localparam logic [SEL_W-1:0] SEL_UP    = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_DOWN  = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_PAUSE = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_CLEAR = 4'b1000;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade (0..9) of the display counter.
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   en               : advance this decade on the next edge
//   up               : direction, 1 = increment, 0 = decrement
//   clr              : synchronous clear to 0 (wins over en)
//   digit            : current decade value
//   carry_out        : carry (up and digit==9) or borrow (down and digit==0)
module bcd_decade
    import counter_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               up,
    input  logic               clr,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry_out
);

    // Carry/borrow is combinational so the enable chain resolves in one cycle.
    assign carry_out = up ? (digit == BCD_MAX) : (digit == '0);

    // Decade register, always kept within 0..9.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (en) begin
            if (up) begin
                digit <= (digit == BCD_MAX) ? '0 : digit + DIGIT_W'(1);
            end else begin
                digit <= (digit == '0) ? BCD_MAX : digit - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_mode_ctrl.sv
// Counter command decoder and prescaled BCD up/down counter.
// Consumes the one-hot key_select from key control, turns changes on it into
// up / down / pause / clear commands and drives a DIGITS-decade BCD counter
// that steps once every CNT_MAX+1 clocks.
// Build option: define COUNTER_SATURATE_EN to saturate at all-9s / all-0s
// instead of wrapping (wrap then flags the limit hit).
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   key_select       : one-hot command select (0000 = none)
//   cnt_bcd          : BCD count, digit 0 in bits [3:0]
//   mode             : 00 HOLD, 01 UP, 10 DOWN
//   step             : one-cycle pulse per count step
//   wrap             : one-cycle pulse on wrap (or limit hit when saturating)
//   sel_err          : one-cycle pulse when key_select changes to a bad code
module counter_mode_ctrl
    import counter_pkg::*;
#(
    parameter logic [PRESC_W-1:0] CNT_MAX = 26'd49_999_999,
    parameter int unsigned        DIGITS  = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [SEL_W-1:0]            key_select,
    output logic [DIGIT_W*DIGITS-1:0]   cnt_bcd,
    output logic [MODE_W-1:0]           mode,
    output logic                        step,
    output logic                        wrap,
    output logic                        sel_err
);

    mode_e               mode_q;
    mode_e               mode_d;
    logic [SEL_W-1:0]    sel_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [PRESC_W-1:0]  presc_d;
    logic                cmd_c;
    logic                cnt_up_c;
    logic                cnt_en_c;
    logic                cnt_clr_c;
    logic                limit_c;
    logic                step_d;
    logic                wrap_d;
    logic                sel_err_d;
    logic [DIGITS-1:0]   dec_en;
    logic [DIGITS-1:0]   dec_carry;

    // A command is a change of key_select to a non-zero value; steady input never re-triggers.
    assign cmd_c    = (key_select != sel_q) && (key_select != '0);
    assign cnt_up_c = (mode_q == MODE_UP);
    // Every decade carrying/borrowing means the count sits at all-9s (up) or all-0s (down).
    assign limit_c  = &dec_carry;
    assign mode     = mode_q;

    // Mode state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q <= MODE_HOLD;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next-state; invalid codes leave the mode untouched.
    always_comb begin
        mode_d = mode_q;
        if (cmd_c) begin
            case (key_select)
                SEL_UP:               mode_d = MODE_UP;
                SEL_DOWN:             mode_d = MODE_DOWN;
                SEL_PAUSE, SEL_CLEAR: mode_d = MODE_HOLD;
                default:              mode_d = mode_q;
            endcase
        end
    end

    // Prescaler, counter control and pulse outputs; a command cycle never steps.
    always_comb begin
        presc_d   = presc_q;
        cnt_en_c  = 1'b0;
        cnt_clr_c = 1'b0;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;
        if (cmd_c) begin
            case (key_select)
                SEL_UP:    if (mode_q == MODE_DOWN) presc_d = '0;
                SEL_DOWN:  if (mode_q == MODE_UP)   presc_d = '0;
                SEL_PAUSE: presc_d = presc_q;
                SEL_CLEAR: begin
                    presc_d   = '0;
                    cnt_clr_c = 1'b1;
                end
                default:   sel_err_d = 1'b1;
            endcase
        end else if (mode_q != MODE_HOLD) begin
            if (presc_q == CNT_MAX) begin
                presc_d = '0;
                step_d  = 1'b1;
                wrap_d  = limit_c;
`ifdef COUNTER_SATURATE_EN
                cnt_en_c = !limit_c;
`else
                cnt_en_c = 1'b1;
`endif
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sel_q   <= '0;
            presc_q <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            sel_q   <= key_select;
            presc_q <= presc_d;
            step    <= step_d;
            wrap    <= wrap_d;
            sel_err <= sel_err_d;
        end
    end

    // Decade chain: decade i advances when the step is enabled and all lower decades carry.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dec
        if (i == 0) begin : g_first
            assign dec_en[i] = cnt_en_c;
        end else begin : g_next
            assign dec_en[i] = cnt_en_c & (&dec_carry[i-1:0]);
        end

        bcd_decade u_decade (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .en        (dec_en[i]),
            .up        (cnt_up_c),
            .clr       (cnt_clr_c),
            .digit     (cnt_bcd[DIGIT_W*i +: DIGIT_W]),
            .carry_out (dec_carry[i])
        );
    end

endmodule

// File: tb/tb_counter_mode_ctrl.sv
// Bench for counter_mode_ctrl: directed vector table, hand sequences for
// borrow/wrap across decades, randomized keys against an integer model.
module tb_counter_mode_ctrl;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_a, key_b;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  mode_a, mode_b;
    logic        step_a, step_b, wrap_a, wrap_b, err_a, err_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance A: CNT_MAX=3 (step every 4 clocks); instance B: CNT_MAX=0 (step every clock).
    counter_mode_ctrl #(.CNT_MAX(26'd3), .DIGITS(4)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst), .key_select(key_a), .cnt_bcd(cnt_a),
        .mode(mode_a), .step(step_a), .wrap(wrap_a), .sel_err(err_a)
    );

    counter_mode_ctrl #(.CNT_MAX(26'd0), .DIGITS(4)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst), .key_select(key_b), .cnt_bcd(cnt_b),
        .mode(mode_b), .step(step_b), .wrap(wrap_b), .sel_err(err_b)
    );

    // Reference model: count as a plain integer 0..9999, mode 0 hold / 1 up / 2 down.
    int         m_cnt  [2];
    int         m_mode [2];
    int         m_pre  [2];
    logic [3:0] m_sel  [2];
    int         m_step [2];
    int         m_wrap [2];
    int         m_err  [2];
    int         m_cmax [2] = '{3, 0};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_mode[i] = 0; m_pre[i] = 0; m_sel[i] = 4'b0000;
            m_step[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_edge(int i, logic [3:0] key);
        m_step[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
        if (key != m_sel[i] && key != 4'b0000) begin
            if (key == 4'b0001) begin
                if (m_mode[i] == 2) m_pre[i] = 0;
                m_mode[i] = 1;
            end else if (key == 4'b0010) begin
                if (m_mode[i] == 1) m_pre[i] = 0;
                m_mode[i] = 2;
            end else if (key == 4'b0100) begin
                m_mode[i] = 0;
            end else if (key == 4'b1000) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_mode[i] = 0;
            end else begin
                m_err[i] = 1;
            end
        end else if (m_mode[i] != 0) begin
            if (m_pre[i] == m_cmax[i]) begin
                m_pre[i]  = 0;
                m_step[i] = 1;
                if (m_mode[i] == 1) begin
                    if (m_cnt[i] == 9999) begin
                        m_wrap[i] = 1;
                        m_cnt[i]  = SAT ? 9999 : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else begin
                    if (m_cnt[i] == 0) begin
                        m_wrap[i] = 1;
                        m_cnt[i]  = SAT ? 0 : 9999;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end else begin
                m_pre[i] = m_pre[i] + 1;
            end
        end
        m_sel[i] = key;
    endtask

    // Non-BCD nibbles map to -1 so they can never match an expected count.
    function automatic int bcd_to_int(logic [15:0] v);
        int acc = 0;
        int mul = 1;
        for (int d = 0; d < 4; d++) begin
            logic [3:0] nib;
            nib = v[4*d +: 4];
            if (nib > 4'd9) return -1;
            acc = acc + int'(nib) * mul;
            mul = mul * 10;
        end
        return acc;
    endfunction

    task automatic cmp(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_dut(int i, string tag);
        if (i == 0) begin
            cmp($sformatf("%s A cnt", tag),  bcd_to_int(cnt_a), m_cnt[0]);
            cmp($sformatf("%s A mode", tag), int'(mode_a),      m_mode[0]);
            cmp($sformatf("%s A step", tag), int'(step_a),      m_step[0]);
            cmp($sformatf("%s A wrap", tag), int'(wrap_a),      m_wrap[0]);
            cmp($sformatf("%s A err", tag),  int'(err_a),       m_err[0]);
        end else begin
            cmp($sformatf("%s B cnt", tag),  bcd_to_int(cnt_b), m_cnt[1]);
            cmp($sformatf("%s B mode", tag), int'(mode_b),      m_mode[1]);
            cmp($sformatf("%s B step", tag), int'(step_b),      m_step[1]);
            cmp($sformatf("%s B wrap", tag), int'(wrap_b),      m_wrap[1]);
            cmp($sformatf("%s B err", tag),  int'(err_b),       m_err[1]);
        end
    endtask

    task automatic check_zero(string tag);
        cmp($sformatf("%s cnt_a", tag),  int'(cnt_a),  0);
        cmp($sformatf("%s mode_a", tag), int'(mode_a), 0);
        cmp($sformatf("%s step_a", tag), int'(step_a), 0);
        cmp($sformatf("%s wrap_a", tag), int'(wrap_a), 0);
        cmp($sformatf("%s err_a", tag),  int'(err_a),  0);
        cmp($sformatf("%s cnt_b", tag),  int'(cnt_b),  0);
        cmp($sformatf("%s mode_b", tag), int'(mode_b), 0);
        cmp($sformatf("%s step_b", tag), int'(step_b), 0);
        cmp($sformatf("%s wrap_b", tag), int'(wrap_b), 0);
        cmp($sformatf("%s err_b", tag),  int'(err_b),  0);
    endtask

    // Drive keys between edges, clock once, advance the model, sample 1 time unit later.
    task automatic tick(logic [3:0] ka, logic [3:0] kb);
        key_a = ka;
        key_b = kb;
        @(posedge clk);
        model_edge(0, ka);
        model_edge(1, kb);
        #1;
    endtask

    function automatic logic [3:0] pick_key();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2)  return 4'b0001;
        if (r < 4)  return 4'b0010;
        if (r == 4) return 4'b0100;
        if (r == 5) return 4'b1000;
        if (r == 6) return 4'b0000;
        return 4'($urandom_range(0, 15));
    endfunction

    typedef struct {
        logic [3:0] key;
        int         mode;
        int         cnt;
        int         step;
        int         wrap;
        int         err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic [3:0] key, int mode, int cnt, int step, int wrap, int err);
        vec_t v;
        v.key = key; v.mode = mode; v.cnt = cnt; v.step = step; v.wrap = wrap; v.err = err;
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0] ka, kb;

        // Expected values after each edge for instance A (CNT_MAX=3).
        add(4'b0001, 1, 0, 0, 0, 0);   // UP taken on first edge after the change
        add(4'b0001, 1, 0, 0, 0, 0);
        add(4'b0001, 1, 0, 0, 0, 0);
        add(4'b0001, 1, 0, 0, 0, 0);
        add(4'b0001, 1, 1, 1, 0, 0);   // first step 4 clocks after mode change
        add(4'b0001, 1, 1, 0, 0, 0);
        add(4'b0001, 1, 1, 0, 0, 0);
        add(4'b0001, 1, 1, 0, 0, 0);
        add(4'b0001, 1, 2, 1, 0, 0);
        add(4'b0001, 1, 2, 0, 0, 0);   // prescaler now 1
        add(4'b0100, 0, 2, 0, 0, 0);   // pause freezes prescaler at 1
        add(4'b0100, 0, 2, 0, 0, 0);
        add(4'b0001, 1, 2, 0, 0, 0);   // resume
        add(4'b0001, 1, 2, 0, 0, 0);
        add(4'b0001, 1, 2, 0, 0, 0);
        add(4'b0001, 1, 3, 1, 0, 0);   // step 3 clocks after resume
        add(4'b0011, 1, 3, 0, 0, 1);   // bad code: sel_err, hold
        add(4'b0011, 1, 3, 0, 0, 0);   // steady bad code: no repeat
        add(4'b1000, 0, 0, 0, 0, 0);   // clear
        for (int k = 0; k < 100; k++) add(4'b1000, 0, 0, 0, 0, 0);
        add(4'b0010, 2, 0, 0, 0, 0);
        add(4'b0010, 2, 0, 0, 0, 0);
        add(4'b0010, 2, 0, 0, 0, 0);
        add(4'b0010, 2, 0, 0, 0, 0);
        add(4'b0010, 2, SAT ? 0 : 9999, 1, 1, 0);   // down past 0000
        add(4'b0010, 2, SAT ? 0 : 9999, 0, 0, 0);   // prescaler 1
        add(4'b0001, 1, SAT ? 0 : 9999, 0, 0, 0);   // direction change clears prescaler
        add(4'b0001, 1, SAT ? 0 : 9999, 0, 0, 0);
        add(4'b0001, 1, SAT ? 0 : 9999, 0, 0, 0);
        add(4'b0001, 1, SAT ? 0 : 9999, 0, 0, 0);
        add(4'b0001, 1, SAT ? 1 : 0, 1, SAT ? 0 : 1, 0);

        rst   = 1'b1;
        key_a = 4'b0000;
        key_b = 4'b0000;
        model_reset();
        #12;
        check_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            tick(tbl[k].key, 4'b0000);
            cmp($sformatf("tbl%0d cnt", k),  bcd_to_int(cnt_a), tbl[k].cnt);
            cmp($sformatf("tbl%0d mode", k), int'(mode_a),      tbl[k].mode);
            cmp($sformatf("tbl%0d step", k), int'(step_a),      tbl[k].step);
            cmp($sformatf("tbl%0d wrap", k), int'(wrap_a),      tbl[k].wrap);
            cmp($sformatf("tbl%0d err", k),  int'(err_a),       tbl[k].err);
        end

        // Instance B: preload 1000, borrow to 0999, then climb to 9999 and wrap.
        tick(4'b0001, 4'b0001);
        cmp("B up mode", int'(mode_b), 1);
        for (int k = 0; k < 1000; k++) begin
            tick(4'b0001, 4'b0001);
            check_dut(0, "pre");
            check_dut(1, "pre");
        end
        cmp("B preload 1000", bcd_to_int(cnt_b), 1000);
        tick(4'b0001, 4'b0010);
        cmp("B down cmd mode", int'(mode_b), 2);
        cmp("B down cmd step", int'(step_b), 0);
        tick(4'b0001, 4'b0010);
        cmp("B borrow raw", int'(cnt_b), 16'h0999);
        cmp("B borrow step", int'(step_b), 1);
        cmp("B borrow wrap", int'(wrap_b), 0);
        tick(4'b0001, 4'b0001);
        cmp("B up again cnt", bcd_to_int(cnt_b), 999);
        for (int k = 0; k < 8999; k++) begin
            tick(4'b0001, 4'b0001);
            check_dut(0, "climb");
            check_dut(1, "climb");
        end
        cmp("B 9998", bcd_to_int(cnt_b), 9998);
        tick(4'b0001, 4'b0001);
        cmp("B 9999 raw", int'(cnt_b), 16'h9999);
        cmp("B 9999 wrap", int'(wrap_b), 0);
        tick(4'b0001, 4'b0001);
        cmp("B top cnt", bcd_to_int(cnt_b), SAT ? 9999 : 0);
        cmp("B top step", int'(step_b), 1);
        cmp("B top wrap", int'(wrap_b), 1);
        cmp("B top mode", int'(mode_b), 1);

        // Randomized key changes against the model.
        ka = 4'b0001;
        kb = 4'b0001;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 4) ka = pick_key();
            if ($urandom_range(0, 99) < 4) kb = pick_key();
            tick(ka, kb);
            check_dut(0, "rnd");
            check_dut(1, "rnd");
        end

        // Reset between edges while counting.
        for (int k = 0; k < 5; k++) tick(4'b0001, 4'b0001);
        tick(4'b0010, 4'b0010);
        for (int k = 0; k < 6; k++) tick(4'b0010, 4'b0010);
        #1;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(4'b0001, 4'b0010);
            check_dut(0, "post");
            check_dut(1, "post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
